wishbone_classic_arbiter: RTL
=============================

# wishbone_classic_arbiter

Round-robin arbiter that shares one Wishbone B4 classic device among `NUM_CTRL` controllers. It sits between several controller ports and a single device port. The winning controller's request signals are muxed onto the device, and the device's response is routed back to that controller only. A grant is held for as long as the winner keeps `cyc` asserted, so back-to-back cycles from one controller are never split.

## Interface
Parameters:
- `DAT_WIDTH`, 8, data bus width, matches the classic interface.
- `NUM_CTRL`, 2, number of controllers; legal range 2..8.
- `TIMEOUT`, 16, wait-state limit in cycles before a forced error; range 2..255; used only with the config macro.

Ports:
- `clk_i`  in  1  single clock for the block.
- `rst_i`  in  1  synchronous, active-high reset.
- `c_cyc_i`, `c_stb_i`, `c_we_i`  in  NUM_CTRL  per-controller request bits; bit k belongs to controller k.
- `c_dat_i`  in  NUM_CTRL*DAT_WIDTH  per-controller write data; controller k uses slice [k*DAT_WIDTH +: DAT_WIDTH].
- `c_ack_o`, `c_err_o`, `c_rty_o`  out  NUM_CTRL  per-controller responses.
- `c_dat_o`  out  DAT_WIDTH  read data, broadcast to all controllers.
- `d_cyc_o`, `d_stb_o`, `d_we_o`  out  1  device request.
- `d_dat_o`  out  DAT_WIDTH  device write data.
- `d_ack_i`, `d_err_i`, `d_rty_i`  in  1  device response.
- `d_dat_i`  in  DAT_WIDTH  device read data.
- `grant_o`  out  NUM_CTRL  registered one-hot grant; all zero when idle.

## Operation
- FSM has two states, IDLE and GRANTED, plus a registered `last` pointer that indexes the most recent winner.
- In IDLE, when any `c_cyc_i` is high:
  - Pick the first requester searching from index `last+1` upward, wrapping modulo NUM_CTRL.
  - Register the winner into `grant_o` and move to GRANTED.
- In GRANTED with winner g:
  - `d_cyc_o`, `d_stb_o`, `d_we_o` and `d_dat_o` are the combinational mux of controller g's inputs.
  - `c_ack_o[g]`, `c_err_o[g]` and `c_rty_o[g]` equal the device responses. All other bits are 0.
  - `c_dat_o` equals `d_dat_i`.
- Release: when `c_cyc_i[g]` goes low, `d_cyc_o` goes low in the same cycle through the mux. On the next edge the FSM enters IDLE, `last` becomes g and `grant_o` clears.
- Non-granted controllers receive no response. They stall with their requests held stable, which is legal classic behaviour.
- In IDLE, all device outputs, all per-controller responses and `c_dat_o` are 0.
- Reset values: state IDLE, `grant_o` = 0, `last` = NUM_CTRL-1 so controller 0 has first priority, timeout counter 0. Every output is 0 while `rst_i` is high.
- Reset mid-cycle: on the edge after `rst_i` the FSM is in IDLE and `d_cyc_o` is 0. The outstanding transfer is abandoned and no response is forwarded.
- Simultaneous requests: the round-robin order alone decides the winner, with no fixed priority beyond it. A request that arrives in the same cycle the grant releases is considered in the next IDLE cycle.

## Timing
- Arbitration latency is 1 clock. A request seen in IDLE at edge t gives `grant_o` and `d_cyc_o` high after edge t+1.
- Handover gap is one IDLE cycle. The previous winner's `cyc` drop is cycle t, IDLE is t+1, and the new `d_cyc_o` is high at t+2.
- Response path is combinational, with zero added latency. A device that acks asynchronously still completes in one cycle on the device side.
- `grant_o` is stable for the whole tenure. It changes only on the IDLE/GRANTED transitions.

## Configuration
- Macro: `WB_ARB_TIMEOUT_EN`.
- When the macro is defined:
  - A counter increments on each GRANTED cycle in which `d_cyc_o && d_stb_o` is high and no device response is present.
  - The counter clears on any response, on leaving GRANTED, and on reset.
  - When the count reaches TIMEOUT, in that cycle the arbiter asserts `c_err_o[g]` = 1 and forces `d_cyc_o`/`d_stb_o` to 0.
  - On the next edge it enters IDLE with `last` = g, even if `c_cyc_i[g]` is still high.
- When the macro is undefined, there is no counter and no forced release. The grant is held until the controller drops `cyc`, however long the device stalls.

## Test plan
- Reset, then controller 0 alone requests a write with `c_dat_i` slice = 8'hA5. Expect `grant_o` = 2'b01 one clock later, `d_dat_o` = 8'hA5, `d_we_o` = 1, and `c_ack_o` = 2'b01 in the same cycle as `d_ack_i`.
- Controllers 0 and 1 request simultaneously and each holds `cyc` for one transfer. Expect grant order 0, IDLE, 1, IDLE. A repeat after both release gives order 0, then 1, from `last` = 1.
- Controller 1 holds `cyc` across 3 acked transfers while controller 0 waits. Expect `grant_o` = 2'b10 throughout, `c_ack_o[0]` = 0, and controller 0 granted 2 clocks after controller 1 drops `cyc`.
- Device read returns `d_dat_i` = 8'h3C with `d_rty_i` = 1. Expect `c_rty_o[g]` = 1, `c_dat_o` = 8'h3C, and zero responses to the other controller.
- Assert `rst_i` for 1 clock mid-transfer. Expect `d_cyc_o` = 0, `grant_o` = 0 and all responses 0 on the following cycle, then controller 0 wins the next arbitration.
- With `WB_ARB_TIMEOUT_EN` and TIMEOUT = 4, the device never responds. Expect `c_err_o[g]` = 1 after 4 stalled cycles, `d_cyc_o` = 0 in that cycle, and the grant rotated to the other pending controller.

Source files
------------

// File: rtl/wishbone_classic_arbiter.sv
// Round-robin arbiter sharing one Wishbone B4 classic device among NUM_CTRL controllers.
// Optional wait-state timeout with forced error/release: define WB_ARB_TIMEOUT_EN.
module wishbone_classic_arbiter #(
    parameter int unsigned DAT_WIDTH = 8,
    parameter int unsigned NUM_CTRL  = 2,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_CTRL-1:0]           c_cyc_i,
    input  logic [NUM_CTRL-1:0]           c_stb_i,
    input  logic [NUM_CTRL-1:0]           c_we_i,
    input  logic [NUM_CTRL*DAT_WIDTH-1:0] c_dat_i,
    output logic [NUM_CTRL-1:0]           c_ack_o,
    output logic [NUM_CTRL-1:0]           c_err_o,
    output logic [NUM_CTRL-1:0]           c_rty_o,
    output logic [DAT_WIDTH-1:0]          c_dat_o,
    output logic                          d_cyc_o,
    output logic                          d_stb_o,
    output logic                          d_we_o,
    output logic [DAT_WIDTH-1:0]          d_dat_o,
    input  logic                          d_ack_i,
    input  logic                          d_err_i,
    input  logic                          d_rty_i,
    input  logic [DAT_WIDTH-1:0]          d_dat_i,
    output logic [NUM_CTRL-1:0]           grant_o
);

    localparam int unsigned IDX_W = $clog2(NUM_CTRL);

    if (NUM_CTRL < 2 || NUM_CTRL > 8 || TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_params
        $error("wishbone_classic_arbiter: parameter out of range");
    end

    typedef enum logic {
        IDLE,
        GRANTED
    } state_t;

    state_t               state_q, state_d;
    logic [NUM_CTRL-1:0]  grant_q, grant_d;
    logic [IDX_W-1:0]     last_q, last_d;
    logic [IDX_W-1:0]     gidx, idx;
    logic                 found;
    logic                 granted;
    logic                 any_rsp;
    logic                 tmo_hit;
    logic                 mux_cyc, mux_stb, mux_we;
    logic [DAT_WIDTH-1:0] mux_dat;

    // One-hot AND-OR mux of the granted controller's request signals.
    always_comb begin
        mux_cyc = 1'b0;
        mux_stb = 1'b0;
        mux_we  = 1'b0;
        mux_dat = '0;
        gidx    = '0;
        for (int unsigned k = 0; k < NUM_CTRL; k++) begin
            if (grant_q[k]) begin
                mux_cyc = c_cyc_i[k];
                mux_stb = c_stb_i[k];
                mux_we  = c_we_i[k];
                mux_dat = c_dat_i[k*DAT_WIDTH +: DAT_WIDTH];
                gidx    = IDX_W'(k);
            end
        end
    end

    assign granted = (state_q == GRANTED) && !rst_i;
    assign any_rsp = d_ack_i | d_err_i | d_rty_i;

`ifdef WB_ARB_TIMEOUT_EN
    logic [7:0] tmo_cnt_q, tmo_cnt_d;

    assign tmo_hit = granted && (tmo_cnt_q == 8'(TIMEOUT));

    always_comb begin
        tmo_cnt_d = '0;
        if (state_q == GRANTED && mux_cyc && mux_stb && !any_rsp && !tmo_hit)
            tmo_cnt_d = tmo_cnt_q + 8'd1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) tmo_cnt_q <= '0;
        else       tmo_cnt_q <= tmo_cnt_d;
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        found   = 1'b0;
        idx     = '0;
        case (state_q)
            IDLE: begin
                grant_d = '0;
                for (int unsigned i = 1; i <= NUM_CTRL; i++) begin
                    idx = IDX_W'((32'(last_q) + i) % NUM_CTRL);
                    if (!found && c_cyc_i[idx]) begin
                        found        = 1'b1;
                        grant_d[idx] = 1'b1;
                    end
                end
                if (found) state_d = GRANTED;
            end
            GRANTED: begin
                if (!mux_cyc || tmo_hit) begin
                    state_d = IDLE;
                    grant_d = '0;
                    last_d  = gidx;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= IDX_W'(NUM_CTRL - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    assign d_cyc_o = granted && mux_cyc && !tmo_hit;
    assign d_stb_o = granted && mux_stb && !tmo_hit;
    assign d_we_o  = granted && mux_we;
    assign d_dat_o = granted ? mux_dat : '0;
    assign c_dat_o = granted ? d_dat_i : '0;
    assign grant_o = rst_i ? '0 : grant_q;
    assign c_ack_o = {NUM_CTRL{granted & d_ack_i}} & grant_q;
    assign c_err_o = {NUM_CTRL{granted & (d_err_i | tmo_hit)}} & grant_q;
    assign c_rty_o = {NUM_CTRL{granted & d_rty_i}} & grant_q;

endmodule
